// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: board-level reset sequencer releasing downstream reset domains in order after PLL lock
module rst_seq_ctrl #(
    parameter int MAIN_CLOCK_PERIOD    = 7,
    parameter int STAGE_NUM            = 4,
    parameter int STAGE_DELAY          = 1000,
    parameter int LOCK_TIMEOUT         = 100000,
    parameter int ACK_TIMEOUT          = 70000,
    parameter int MAX_RETRY            = 3,
    parameter bit OUT_RST_ACTIVE_LEVEL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pll_locked,
    input  logic [STAGE_NUM-1:0] stage_done,
    input  logic                 soft_rst_req,
    output logic [STAGE_NUM-1:0] stage_rst,
    output logic                 seq_done,
    output logic                 seq_fail,
    output logic [3:0]           retry_cnt,
    output logic [2:0]           seq_state
);
    localparam int DELAY_RAW = STAGE_DELAY / MAIN_CLOCK_PERIOD;
    localparam int LOCK_RAW  = LOCK_TIMEOUT / MAIN_CLOCK_PERIOD;
    localparam int ACK_RAW   = ACK_TIMEOUT / MAIN_CLOCK_PERIOD;
    localparam logic [31:0] DELAY_LAST = 32'((DELAY_RAW > 1) ? DELAY_RAW - 1 : 0);
    localparam logic [31:0] LOCK_LAST  = 32'((LOCK_RAW > 1) ? LOCK_RAW - 1 : 0);
    localparam logic [31:0] ACK_LAST   = 32'((ACK_RAW > 1) ? ACK_RAW - 1 : 0);
    localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRY);
    localparam logic [2:0]  LAST_IDX   = 3'(STAGE_NUM - 1);
    localparam logic [STAGE_NUM-1:0] ALL_ASSERT = {STAGE_NUM{OUT_RST_ACTIVE_LEVEL}};
    localparam logic [STAGE_NUM-1:0] FIRST_MASK = STAGE_NUM'(1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_SETTLE    = 3'd2;
    localparam logic [2:0] S_ACK       = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;
    localparam logic [2:0] S_RUN       = 3'd5;
    localparam logic [2:0] S_HOLD      = 3'd6;
    localparam logic [2:0] S_FAIL      = 3'd7;

    logic [1:0]           sync_q;
    logic                 lock_s;
    logic [2:0]           state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [STAGE_NUM-1:0] rst_q, rst_d;
    logic                 done_q, done_d;
    logic                 fail_q, fail_d;
    logic [3:0]           rc_q, rc_d;
    logic [7:0]           done_w;
    logic [STAGE_NUM-1:0] rel_mask;
    logic                 loss_ev, retry_ev;

    // Drive the masked stages to their inactive level, leave the others untouched
    function automatic logic [STAGE_NUM-1:0] release_bits(input logic [STAGE_NUM-1:0] cur,
                                                          input logic [STAGE_NUM-1:0] mask);
        return (cur & ~mask) | (~ALL_ASSERT & mask);
    endfunction

    assign lock_s    = sync_q[1];
    assign done_w    = 8'(stage_done);
    assign rel_mask  = STAGE_NUM'(8'd1 << idx_q);
    assign stage_rst = rst_q;
    assign seq_done  = done_q;
    assign seq_fail  = fail_q;
    assign retry_cnt = rc_q;
    assign seq_state = state_q;

    // Two-flop synchronizer for the asynchronous PLL lock indication
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= 2'b00;
        else      sync_q <= {sync_q[0], pll_locked};
    end

    // Sequencer next state: soft request beats lock loss beats ack beats timeout
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rst_d    = rst_q;
        done_d   = done_q;
        fail_d   = fail_q;
        rc_d     = rc_q;
        loss_ev  = 1'b0;
        retry_ev = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (lock_s) state_d = S_SETTLE;
                else if (cnt_q == LOCK_LAST) retry_ev = 1'b1;
            end
            S_SETTLE: begin
                if (!lock_s) state_d = S_WAIT_LOCK;
                else if (cnt_q == DELAY_LAST) begin
                    idx_d   = 3'd0;
                    rst_d   = release_bits(ALL_ASSERT, FIRST_MASK);
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!lock_s) loss_ev = 1'b1;
                else if (done_w[idx_q]) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_GAP;
                    end
                end else if (cnt_q == ACK_LAST) retry_ev = 1'b1;
            end
            S_GAP: begin
                if (!lock_s) loss_ev = 1'b1;
                else if (cnt_q == DELAY_LAST) begin
                    rst_d   = release_bits(rst_q, rel_mask);
                    state_d = S_ACK;
                end
            end
            S_RUN:  loss_ev = !lock_s;
            S_HOLD: state_d = (cnt_q == DELAY_LAST) ? S_WAIT_LOCK : S_HOLD;
            default: state_d = state_q;
        endcase
        if (loss_ev) begin
            rst_d   = ALL_ASSERT;
            done_d  = 1'b0;
            state_d = S_HOLD;
        end
        if (retry_ev) begin
            rst_d  = ALL_ASSERT;
            done_d = 1'b0;
            if (rc_q >= RETRY_MAX) begin
                state_d = S_FAIL;
                fail_d  = 1'b1;
            end else begin
                rc_d    = rc_q + 4'd1;
                state_d = S_HOLD;
            end
        end
        if (soft_rst_req) begin
            rst_d   = ALL_ASSERT;
            done_d  = 1'b0;
            fail_d  = 1'b0;
            rc_d    = 4'd0;
            state_d = S_HOLD;
        end
        cnt_d = (soft_rst_req || state_d != state_q) ? 32'd0 : cnt_q + 32'd1;
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 32'd0;
            idx_q   <= 3'd0;
            rst_q   <= ALL_ASSERT;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            rc_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            rc_q    <= rc_d;
        end
    end
endmodule
